// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bitstream writer/reader pair:
// FSM states, bus register map and word geometry.
package huffman_pkg;

    localparam int WORD_W = 32;
    localparam int ACC_W  = 64;
    localparam int FILL_W = 7;

    localparam logic [31:0] HUFF_STATUS_ADDR = 32'd2000;
    localparam logic [31:0] HUFF_DATA_ADDR   = 32'd2001;
    localparam logic [31:0] HUFF_BITS_ADDR   = 32'd2002;
    localparam logic [2:0]  HSIZE_WORD       = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_FLUSH,
        ST_DONE
    } huff_state_t;

    // Codes of length 0 or above one word are dropped by the packer.
    function automatic logic len_ok(input logic [5:0] len);
        return (len != 6'd0) && (len <= 6'd32);
    endfunction

endpackage

// File: rtl/huffman_fifo.sv
// Circular word buffer between the bit packer and the bus pop port.
// A push into a full buffer succeeds when a pop happens in the same cycle.
module huffman_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/huffman_write.sv
// Huffman bitstream writer: packs variable-length codes MSB-first into
// 32-bit words, queues them, and exposes them over a zero-wait read bus.
module huffman_write
    import huffman_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] STATUS_ADDR = HUFF_STATUS_ADDR,
    parameter logic [31:0] DATA_ADDR   = HUFF_DATA_ADDR,
    parameter logic [31:0] BITS_ADDR   = HUFF_BITS_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [WORD_W-1:0] code,
    input  logic [5:0]        code_len,
    output logic              code_ready,
    input  logic              flush,
    input  logic              clear,
    input  logic [31:0]       HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    output logic [WORD_W-1:0] HRDATA,
    output logic              HRESP,
    output logic              done,
    output logic [31:0]       bit_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    huff_state_t       state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next, acc_base, code_bits;
    logic [FILL_W-1:0] fill_reg, fill_next, fill_base, ins_shift;
    logic [31:0]       bit_count_reg, bit_count_next;

    logic [31:0]       addr_reg;
    logic              write_reg;
    logic [2:0]        size_reg;
    logic              dphase_reg;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_W-1:0] fifo_head;
    logic              space, accept;
    logic              is_status, is_data, is_bits, legal;
    logic [WORD_W-1:0] status_word;

    huffman_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (acc_reg[ACC_W-1 -: WORD_W]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Address phase is captured every cycle; the following cycle is its data phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            size_reg   <= '0;
            dphase_reg <= 1'b0;
        end else begin
            addr_reg   <= HADDR;
            write_reg  <= HWRITE;
            size_reg   <= HSIZE;
            dphase_reg <= 1'b1;
        end
    end

    always_comb begin
        is_status   = (addr_reg == STATUS_ADDR);
        is_data     = (addr_reg == DATA_ADDR);
        is_bits     = (addr_reg == BITS_ADDR);
        legal       = dphase_reg && !write_reg && (size_reg == HSIZE_WORD)
                      && (is_status || is_data || is_bits);
        fifo_pop    = legal && is_data && !fifo_empty;
        status_word = {16'(fifo_count), 13'b0, fifo_full, (state_reg == ST_DONE), !fifo_empty};
        HRDATA      = '0;
        HRESP       = 1'b0;
        if (dphase_reg) begin
            if (!legal || (is_data && fifo_empty)) begin
                HRESP = 1'b1;
            end else if (is_status) begin
                HRDATA = status_word;
            end else if (is_data) begin
                HRDATA = fifo_head;
            end else begin
                HRDATA = bit_count_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            fill_reg      <= '0;
            bit_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            fill_reg      <= fill_next;
            bit_count_reg <= bit_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        fill_next      = fill_reg;
        bit_count_next = bit_count_reg;
        fifo_push      = 1'b0;
        code_ready     = 1'b0;
        accept         = 1'b0;
        acc_base       = acc_reg;
        fill_base      = fill_reg;
        ins_shift      = '0;
        space          = !fifo_full || fifo_pop;
        code_bits      = {32'b0, code} & ((64'd1 << code_len) - 64'd1);

        case (state_reg)
            ST_IDLE: begin
                if (flush) begin
                    state_next = ST_DONE;
                end else if (code_valid && len_ok(code_len)) begin
                    state_next = ST_PACK;
                end
            end
            ST_PACK: begin
                if (fill_reg >= 7'd32 && space) begin
                    fifo_push = 1'b1;
                    acc_base  = acc_reg << 32;
                    fill_base = fill_reg - 7'd32;
                end
                // At exactly one full word, accept only when that word leaves this cycle.
                code_ready = (fill_reg < 7'd32) || (fill_reg == 7'd32 && space);
                accept     = code_valid && code_ready && len_ok(code_len);
                ins_shift  = 7'd64 - fill_base - {1'b0, code_len};
                acc_next   = acc_base;
                fill_next  = fill_base;
                if (accept) begin
                    acc_next       = acc_base | (code_bits << ins_shift);
                    fill_next      = fill_base + {1'b0, code_len};
                    bit_count_next = bit_count_reg + {26'b0, code_len};
                end
                if (flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_reg == '0) begin
                    state_next = ST_DONE;
                end else if (space) begin
                    fifo_push = 1'b1;
                    if (fill_reg > 7'd32) begin
                        acc_next  = acc_reg << 32;
                        fill_next = fill_reg - 7'd32;
                    end else begin
                        acc_next   = '0;
                        fill_next  = '0;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_next     = ST_IDLE;
                    acc_next       = '0;
                    fill_next      = '0;
                    bit_count_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign done      = (state_reg == ST_DONE);
    assign bit_count = bit_count_reg;

endmodule

// File: doc/huffman_write.md
HUFFMAN_WRITE -- requirements
Module: huffman_write

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 8, output word buffer depth; STATUS_ADDR, default 2000, status register; DATA_ADDR, default 2001, data pop port; BITS_ADDR, default 2002, total-bits register.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports named clk and reset.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 reset  in  1  async active-low reset.
REQ-005 code_valid  in  1  encoder offers a code this cycle.
REQ-006 code  in  32  code bits, right-justified, emitted MSB-first.
REQ-007 code_len  in  6  valid bits in code, 1..32.
REQ-008 code_ready  out  1  block accepts the code this cycle.
REQ-009 flush  in  1  end of stream; pad and emit the last partial word.
REQ-010 clear  in  1  return to IDLE from DONE; zero all counters.
REQ-011 HADDR  in  32  bus address, address phase.
REQ-012 HWRITE  in  1  1 = write (ignored), 0 = read.
REQ-013 HSIZE  in  3  only 3'd2 (word) is legal.
REQ-014 HRDATA  out  32  read data, data phase.
REQ-015 HRESP  out  1  1 = error for the current data phase.
REQ-016 done  out  1  flush complete; all words queued.
REQ-017 bit_count  out  32  total code bits accepted since clear, padding excluded.

Function
REQ-018 SHALL accept a code when code_valid && code_ready; code_len 0 or greater than 32 SHALL be dropped and SHALL NOT alter any state.
REQ-019 SHALL pack codes MSB-first into a 64-bit accumulator with a fill count of 0..64; the first code bit lands at bit 31 of the word.
REQ-020 code_ready SHALL be 1 only in PACK with fill <= 32, so an accepted code never overflows the accumulator.
REQ-021 When fill >= 32 and the FIFO is not full, SHALL push the top 32 bits and set fill to fill-32 in the same cycle; a push and an accept in the same cycle SHALL both take effect.
REQ-022 States: IDLE -> PACK on the first code_valid; PACK -> FLUSH on flush; FLUSH -> DONE when fill == 0 and the padded word is pushed; DONE -> IDLE on clear.
REQ-023 In FLUSH: code_ready = 0; a residual fill of 1..31 SHALL be zero-padded to 32 bits and pushed when the FIFO has space.
REQ-024 flush in IDLE SHALL go directly to DONE with no word pushed.
REQ-025 done SHALL be 1 only in DONE; clear outside DONE SHALL be ignored.
REQ-026 Bus timing: address, HWRITE and HSIZE SHALL be registered in the address phase; HRDATA and HRESP SHALL be driven in the next cycle (data phase), with zero wait states.
REQ-027 Read of STATUS_ADDR SHALL return {16'(FIFO entries), 13'b0, fifo_full, done, fifo_not_empty}.
REQ-028 Read of DATA_ADDR with a non-empty FIFO SHALL return the head word and pop it in the data phase; with an empty FIFO it SHALL return 0 and HRESP = 1.
REQ-029 Read of BITS_ADDR SHALL return bit_count.
REQ-030 An unmapped address, HSIZE != 2, or HWRITE = 1 to a mapped address SHALL give HRESP = 1 and HRDATA = 0, with no state change.
REQ-031 A pop and a push in the same cycle on a full FIFO SHALL both succeed, and the count SHALL stay unchanged.
REQ-032 HRESP and HRDATA SHALL be 0 in any cycle without a data phase.

Reset
REQ-033 reset low SHALL immediately force: state IDLE, fill 0, FIFO empty, bit_count 0, code_ready 0, done 0, HRDATA 0, HRESP 0, registered address phase invalid.
REQ-034 Reset mid-stream SHALL discard all buffered and partial bits; no stale word is readable afterwards.

Structure
REQ-035 Package huffman_pkg SHALL hold the state enum, address constants and word width, shared with Huffman_Read.
REQ-036 The FIFO SHALL be a sub-module, huffman_fifo, a synchronous circular buffer with full, empty and count outputs.

Verification
REQ-037 Codes (101b,3), (1b,1), (1111b,4), then flush, then read DATA_ADDR -> HRDATA = 0xBF000000; BITS_ADDR reads 8; done = 1.
REQ-038 Codes (101b,3), (0xFFFFFFFF,32), flush -> two reads return 0xBFFFFFFF then 0xE0000000; bit_count = 35.
REQ-039 Read DATA_ADDR on an empty FIFO -> HRDATA = 0, HRESP = 1 for one cycle; STATUS_ADDR reads 0.
REQ-040 Twenty codes (0xFFFF,16) with no reads -> 8 words queued, fill 32, code_ready = 0, STATUS bit2 = 1; one read releases the stall; all 10 words read back as 0xFFFFFFFF.
REQ-041 Assert reset after 5 accepted codes -> all outputs 0; STATUS reads 0; a new stream after release packs from bit 31.
REQ-042 Read with HSIZE = 0, a write to DATA_ADDR, and a read of address 1999 -> each gives HRESP = 1 and the FIFO count is unchanged.
